// File: rtl/clear_then_circle.sv
// Sequencer in front of the circle drawer: optionally clears the framebuffer,
// then hands the VGA pixel-write port to the drawer until it reports done.
module clear_then_circle #(
  parameter int          SCREEN_W    = 160,
  parameter int          SCREEN_H    = 120,
  parameter logic [2:0]  FILL_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       clear_en,
  output logic       done,
  output logic       circle_start,
  input  logic       circle_done,
  input  logic [7:0] circle_x,
  input  logic [6:0] circle_y,
  input  logic [2:0] circle_colour,
  input  logic       circle_plot,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot
);

  typedef enum logic [1:0] {IDLE, FILL, CIRCLE, DONE} state_t;

  localparam logic [7:0] LAST_X = 8'(SCREEN_W - 1);
  localparam logic [6:0] LAST_Y = 7'(SCREEN_H - 1);

  state_t     state_q, state_d;
  logic [7:0] fx_q, fx_d;
  logic [6:0] fy_q, fy_d;
  logic       armed_q, armed_d;

  always_comb begin
    state_d = state_q;
    fx_d    = fx_q;
    fy_d    = fy_q;
    armed_d = armed_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = clear_en ? FILL : CIRCLE;
          fx_d    = 8'd0;
          fy_d    = 7'd0;
          armed_d = 1'b0;
        end
      end
      FILL: begin
        // Column-major sweep: y runs fastest, x advances when a column completes.
        if (fy_q == LAST_Y) begin
          fy_d = 7'd0;
          if (fx_q == LAST_X) begin
            fx_d    = 8'd0;
            state_d = CIRCLE;
          end else begin
            fx_d = fx_q + 8'd1;
          end
        end else begin
          fy_d = fy_q + 7'd1;
        end
      end
      CIRCLE: begin
        // A done left high from a previous run is ignored until it has been seen low.
        if (!circle_done) armed_d = 1'b1;
        if (armed_q && circle_done) state_d = DONE;
      end
      DONE: begin
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      fx_q    <= 8'd0;
      fy_q    <= 7'd0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fx_q    <= fx_d;
      fy_q    <= fy_d;
      armed_q <= armed_d;
    end
  end

  always_comb begin
    done         = 1'b0;
    circle_start = 1'b0;
    vga_x        = 8'd0;
    vga_y        = 7'd0;
    vga_colour   = 3'd0;
    vga_plot     = 1'b0;
    unique case (state_q)
      FILL: begin
        vga_x      = fx_q;
        vga_y      = fy_q;
        vga_colour = FILL_COLOUR;
        vga_plot   = 1'b1;
      end
      CIRCLE: begin
        circle_start = 1'b1;
        vga_x        = circle_x;
        vga_y        = circle_y;
        vga_colour   = circle_colour;
        vga_plot     = circle_plot;
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_clear_then_circle.sv
// Directed bench for clear_then_circle: inputs change 1ns after a rising edge,
// outputs are checked on the falling edge.
module tb_clear_then_circle;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       clear_en;
  logic       done;
  logic       circle_start;
  logic       circle_done;
  logic [7:0] circle_x;
  logic [6:0] circle_y;
  logic [2:0] circle_colour;
  logic       circle_plot;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  int compared   = 0;
  int mismatched = 0;

  clear_then_circle dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear_en(clear_en),
    .done(done), .circle_start(circle_start), .circle_done(circle_done),
    .circle_x(circle_x), .circle_y(circle_y), .circle_colour(circle_colour),
    .circle_plot(circle_plot), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; clear_en = 1'b0; circle_done = 1'b0;
    circle_x = 8'd0; circle_y = 7'd0; circle_colour = 3'd0; circle_plot = 1'b0;
    #2;
    compared++;
    if ({done, circle_start, vga_x, vga_y, vga_colour, vga_plot} !== 21'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: got %h want 0",
               {done, circle_start, vga_x, vga_y, vga_colour, vga_plot});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // Runs the full clear pass from IDLE and checks every pixel in scan order.
  task automatic test_fill();
    int errs = 0;
    int ex, ey;
    start = 1'b1; clear_en = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 19200; i++) begin
      @(negedge clk);
      ex = i / 120; ey = i % 120;
      if (vga_plot !== 1'b1 || vga_x !== 8'(ex) || vga_y !== 7'(ey) ||
          vga_colour !== 3'b000 || circle_start !== 1'b0 || done !== 1'b0) begin
        if (errs == 0)
          $display("[TB] FAIL fill_pixel_%0d: got plot=%b (%0d,%0d) c=%0d cs=%b want plot=1 (%0d,%0d) c=0 cs=0",
                   i, vga_plot, vga_x, vga_y, vga_colour, circle_start, ex, ey);
        errs++;
      end
      if (i == 0 || i == 1 || i == 120 || i == 19199) begin
        compared++;
        if (vga_x !== 8'(ex) || vga_y !== 7'(ey) || vga_plot !== 1'b1) begin
          mismatched++;
          $display("[TB] FAIL fill_key_%0d: got (%0d,%0d) plot=%b want (%0d,%0d) plot=1",
                   i, vga_x, vga_y, vga_plot, ex, ey);
        end
      end
      @(posedge clk);
    end
    compared++;
    if (errs != 0) begin
      mismatched++;
      $display("[TB] FAIL fill_sweep: got %0d bad cycles want 0", errs);
    end
    @(negedge clk);
    compared++;
    if (circle_start !== 1'b1 || vga_plot !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL fill_to_circle: got cs=%b plot=%b want cs=1 plot=0", circle_start, vga_plot);
    end
  endtask

  // Continues in CIRCLE left by test_fill.
  task automatic test_passthrough();
    tick();
    circle_x = 8'd80; circle_y = 7'd60; circle_colour = 3'b010; circle_plot = 1'b1;
    @(negedge clk);
    compared++;
    if (vga_x !== 8'd80 || vga_y !== 7'd60 || vga_colour !== 3'b010 || vga_plot !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL passthrough: got (%0d,%0d) c=%0d p=%b want (80,60) c=2 p=1",
               vga_x, vga_y, vga_colour, vga_plot);
    end
    tick();
    circle_done = 1'b1;
    tick();
    @(negedge clk);
    compared++;
    if (done !== 1'b1 || vga_plot !== 1'b0 || vga_x !== 8'd0 || circle_start !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL done_outputs: got done=%b plot=%b x=%0d cs=%b want done=1 plot=0 x=0 cs=0",
               done, vga_plot, vga_x, circle_start);
    end
    tick();
    compared++;
    if (done !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL done_hold: got %b want 1", done);
    end
    start = 1'b0; circle_done = 1'b0; circle_plot = 1'b0;
    tick();
    @(negedge clk);
    compared++;
    if (done !== 1'b0 || circle_start !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL done_to_idle: got done=%b cs=%b want 0 0", done, circle_start);
    end
  endtask

  task automatic test_no_clear();
    int errs = 0;
    start = 1'b1; clear_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    compared++;
    if (circle_start !== 1'b1 || vga_plot !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL noclear_start: got cs=%b plot=%b want cs=1 plot=0", circle_start, vga_plot);
    end
    for (int c = 1; c < 50; c++) begin
      tick();
      @(negedge clk);
      if (done !== 1'b0 || circle_start !== 1'b1) errs++;
    end
    compared++;
    if (errs != 0) begin
      mismatched++;
      $display("[TB] FAIL noclear_wait: got %0d bad cycles want 0", errs);
    end
    tick();
    circle_done = 1'b1;
    @(negedge clk);
    compared++;
    if (done !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL noclear_early_done: got %b want 0", done);
    end
    tick();
    @(negedge clk);
    compared++;
    if (done !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL noclear_done: got %b want 1", done);
    end
    tick();
    start = 1'b0; circle_done = 1'b0;
    tick();
    @(negedge clk);
    compared++;
    if (done !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL noclear_idle: got %b want 0", done);
    end
  endtask

  task automatic test_stale_done();
    int errs = 0;
    start = 1'b1; clear_en = 1'b0; circle_done = 1'b1;
    @(posedge clk);
    for (int c = 1; c < 40; c++) begin
      if (c == 3) begin
        #1 circle_done = 1'b0;
      end
      @(negedge clk);
      if (done !== 1'b0 || circle_start !== 1'b1) errs++;
      @(posedge clk);
    end
    compared++;
    if (errs != 0) begin
      mismatched++;
      $display("[TB] FAIL stale_done_early: got %0d bad cycles want 0", errs);
    end
    #1 circle_done = 1'b1;
    @(negedge clk);
    compared++;
    if (done !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL stale_done_same_cycle: got %b want 0", done);
    end
    tick();
    @(negedge clk);
    compared++;
    if (done !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL stale_done_rise: got %b want 1", done);
    end
    tick();
    start = 1'b0; circle_done = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_fill();
    int idx = 37 * 120 + 12;
    start = 1'b1; clear_en = 1'b1;
    @(posedge clk);
    for (int i = 0; i < idx; i++) @(posedge clk);
    @(negedge clk);
    compared++;
    if (vga_x !== 8'd37 || vga_y !== 7'd12 || vga_plot !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL midfill_pixel: got (%0d,%0d) p=%b want (37,12) p=1", vga_x, vga_y, vga_plot);
    end
    #1 rst_n = 1'b0;
    #1;
    compared++;
    if ({done, circle_start, vga_x, vga_y, vga_colour, vga_plot} !== 21'd0) begin
      mismatched++;
      $display("[TB] FAIL midfill_reset: got %h want 0",
               {done, circle_start, vga_x, vga_y, vga_colour, vga_plot});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    compared++;
    if (vga_x !== 8'd0 || vga_y !== 7'd0 || vga_plot !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL midfill_restart: got (%0d,%0d) p=%b want (0,0) p=1", vga_x, vga_y, vga_plot);
    end
    rst_n = 1'b0; start = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_start_drop();
    int plots = 0;
    start = 1'b1; clear_en = 1'b1; circle_done = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 19300; i++) begin
      @(negedge clk);
      if (i == 100) start = 1'b0;
      if (vga_plot === 1'b1) plots++;
      else break;
      @(posedge clk);
    end
    compared++;
    if (plots != 19200 || circle_start !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL drop_fill_count: got %0d cs=%b want 19200 cs=1", plots, circle_start);
    end
    tick();
    tick();
    circle_done = 1'b1;
    tick();
    @(negedge clk);
    compared++;
    if (done !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL drop_done_pulse: got %b want 1", done);
    end
    circle_done = 1'b0;
    @(posedge clk);
    @(negedge clk);
    compared++;
    if (done !== 1'b0 || circle_start !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL drop_back_idle: got done=%b cs=%b want 0 0", done, circle_start);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_passthrough();
    test_no_clear();
    test_stale_done();
    test_reset_mid_fill();
    test_start_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
